// File: rtl/daq_pkg.sv
// daq_pkg: framing constants and FSM states shared by the event saver and streamer.
package daq_pkg;
  localparam int WORDS_PER_EVENT = 16;
  localparam logic [15:0] HDR_TAG = 16'hE7E7;
  typedef enum logic [2:0] {IDLE, HDR, RD, LAT, HI, LO} streamer_state_t;
endpackage

// File: rtl/event_streamer.sv
// event_streamer: drains whole events from a non-FWFT FIFO as a framed 32-bit valid/ready stream.
module event_streamer #(
  parameter int WORDS_PER_EVENT = daq_pkg::WORDS_PER_EVENT,
  parameter logic [15:0] HDR_TAG = daq_pkg::HDR_TAG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [63:0] dout_i,
  input  logic        empty_i,
  output logic        rd_en_o,
  output logic [31:0] m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        m_first_o,
  output logic        m_last_o,
  output logic [15:0] event_cnt_o,
  output logic        busy_o
);
  import daq_pkg::*;
  localparam int IW = WORDS_PER_EVENT > 1 ? $clog2(WORDS_PER_EVENT) : 1;
  streamer_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [63:0] word_q, word_d;
  logic [15:0] cnt_q, cnt_d;
  logic hs;
  assign m_valid_o = state_q == HDR || state_q == HI || state_q == LO;
  assign m_first_o = state_q == HDR;
  assign m_last_o = state_q == LO && idx_q == IW'(WORDS_PER_EVENT - 1);
  assign rd_en_o = state_q == RD && !empty_i;
  assign busy_o = state_q != IDLE;
  assign event_cnt_o = cnt_q;
  assign hs = m_valid_o && m_ready_i;
  // Beat data is decoded from state so it holds naturally while stalled.
  assign m_data_o = state_q == HDR ? {HDR_TAG, cnt_q} :
                    state_q == HI  ? word_q[63:32] :
                    state_q == LO  ? word_q[31:0] : '0;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    word_d = word_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: state_d = enable_i && !empty_i ? HDR : IDLE;
      HDR: begin
        idx_d = hs ? '0 : idx_q;
        state_d = hs ? RD : HDR;
      end
      RD: state_d = empty_i ? RD : LAT;
      LAT: begin
        word_d = dout_i;
        state_d = HI;
      end
      HI: state_d = hs ? LO : HI;
      LO: if (hs) begin
        cnt_d = m_last_o ? cnt_q + 16'd1 : cnt_q;
        idx_d = m_last_o ? idx_q : idx_q + 1'b1;
        state_d = m_last_o ? IDLE : RD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      word_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      word_q <= word_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_event_streamer.sv
// tb_event_streamer: FIFO model plus beat-level reference model checked every cycle, with directed scenarios.
module tb_event_streamer;
  localparam int W = 16;
  localparam int BEATS = 2 * W + 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable_i = 1'b0;
  logic m_ready_i = 1'b1;
  logic [63:0] dout_i = '0;
  logic empty_i, rd_en_o, m_valid_o, m_first_o, m_last_o, busy_o;
  logic [31:0] m_data_o;
  logic [15:0] event_cnt_o;
  int errors = 0;
  int checks = 0;
  logic [63:0] fifo[$];
  logic [63:0] exp_words[$];
  logic [31:0] hdr_log[$];
  int pos = 0;
  int done_events = 0;
  int rd_seen = 0;
  int valid_seen = 0;
  logic [15:0] mcnt = '0;
  logic bp = 1'b0;
  logic [7:0] lfsr = 8'hA5;
  logic stall_q = 1'b0;
  logic [34:0] stall_v = '0;
  logic [63:0] w;
  event_streamer dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .dout_i(dout_i), .empty_i(empty_i),
    .rd_en_o(rd_en_o), .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_first_o(m_first_o), .m_last_o(m_last_o), .event_cnt_o(event_cnt_o), .busy_o(busy_o)
  );
  always #4 clk = ~clk;
  assign empty_i = fifo.size() == 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push_words(input int first, input int n);
    logic [63:0] v;
    for (int i = first; i < first + n; i++) begin
      v = {32'(i), 32'h1000 + 32'(i)};
      fifo.push_back(v);
      exp_words.push_back(v);
    end
  endtask
  task automatic wait_events(input int target, input string name);
    int n;
    n = 0;
    while (done_events < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check(name, 64'(done_events >= target), 64'd1);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while (pos < p && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("wait_pos", 64'(pos >= p), 64'd1);
  endtask
  // Non-FWFT FIFO: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (!rst) fifo.delete();
    else if (rd_en_o && fifo.size() > 0) dout_i <= fifo.pop_front();
  end
  initial begin
    forever begin
      @(posedge clk);
      #1;
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      m_ready_i = bp ? lfsr[0] : 1'b1;
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      exp_words.delete();
      pos = 0;
      mcnt = '0;
      stall_q = 1'b0;
    end else begin
      check("event_cnt", 64'(event_cnt_o), 64'(mcnt));
      check("rd_en_protocol", 64'(rd_en_o && (empty_i || m_valid_o)), 64'd0);
      if (m_valid_o || rd_en_o) check("busy", 64'(busy_o), 64'd1);
      if (stall_q) check("stall_hold", 64'({m_valid_o, m_first_o, m_last_o, m_data_o}), 64'(stall_v));
      if (rd_en_o) rd_seen++;
      if (m_valid_o) valid_seen++;
      if (m_valid_o && m_ready_i) begin
        if (pos == 0) begin
          check("header", 64'({m_first_o, m_last_o, m_data_o}), 64'({2'b10, 16'hE7E7, mcnt}));
          hdr_log.push_back(m_data_o);
        end else begin
          w = exp_words.size() > (pos - 1) / 2 ? exp_words[(pos - 1) / 2] : 64'hBAD0_BAD0_BAD0_BAD0;
          check("beat", 64'({m_first_o, m_last_o, m_data_o}),
                64'({1'b0, pos == BEATS - 1, pos[0] ? w[63:32] : w[31:0]}));
        end
        pos++;
        if (pos == BEATS) begin
          pos = 0;
          mcnt++;
          done_events++;
          for (int i = 0; i < W; i++) if (exp_words.size() > 0) void'(exp_words.pop_front());
        end
      end
      stall_q = m_valid_o && !m_ready_i;
      stall_v = {m_valid_o, m_first_o, m_last_o, m_data_o};
    end
  end
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({rd_en_o, m_valid_o, m_first_o, m_last_o, busy_o}), 64'd0);
    check("reset_data", 64'({m_data_o, event_cnt_o}), 64'd0);
    rst = 1'b1;
    // Enable gating: a full event waits while enable is low.
    push_words(0, W);
    repeat (20) @(posedge clk);
    #1;
    check("gate_idle", 64'(rd_seen + valid_seen + 32'(busy_o)), 64'd0);
    // Single event, ready always high: 66 cycles from start to IDLE.
    enable_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy_o && n < 200);
    enable_i = 1'b0;
    check("event_cycles", 64'(n), 64'd66);
    check("first_header", 64'(hdr_log.size() > 0 ? hdr_log[0] : 32'h0), 64'h0000_0000_E7E7_0000);
    check("count_after_1", 64'(event_cnt_o), 64'd1);
    // Back-pressure.
    bp = 1'b1;
    push_words(16, W);
    enable_i = 1'b1;
    wait_events(2, "bp_done");
    enable_i = 1'b0;
    bp = 1'b0;
    check("second_header", 64'(hdr_log.size() > 1 ? hdr_log[1] : 32'h0), 64'h0000_0000_E7E7_0001);
    // FIFO runs dry mid-event: streamer parks in RD.
    push_words(32, 5);
    enable_i = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("parked", 64'({busy_o, rd_en_o, m_valid_o}), 64'b100);
    push_words(37, W - 5);
    wait_events(3, "refill_done");
    enable_i = 1'b0;
    // Dropping enable during beat 10 still completes the event.
    push_words(48, W);
    enable_i = 1'b1;
    wait_pos(10);
    #1;
    enable_i = 1'b0;
    wait_events(4, "drop_enable_done");
    check("count_after_4", 64'(event_cnt_o), 64'd4);
    // Reset after beat 7 abandons the event.
    push_words(64, W);
    enable_i = 1'b1;
    wait_pos(8);
    #1;
    rst = 1'b0;
    enable_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("midrst_ctrl", 64'({rd_en_o, m_valid_o, m_first_o, m_last_o, busy_o}), 64'd0);
    check("midrst_data", 64'({m_data_o, event_cnt_o}), 64'd0);
    // Counter wrap: preload the count to all-ones, stream two events.
    force dut.cnt_q = 16'hFFFF;
    mcnt = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.cnt_q;
    push_words(80, 2 * W);
    enable_i = 1'b1;
    wait_events(done_events + 2, "wrap_done");
    enable_i = 1'b0;
    n = hdr_log.size();
    check("wrap_hdr_ffff", 64'(n > 1 ? hdr_log[n-2] : 32'h0), 64'h0000_0000_E7E7_FFFF);
    check("wrap_hdr_0000", 64'(n > 0 ? hdr_log[n-1] : 32'h0), 64'h0000_0000_E7E7_0000);
    check("wrap_count", 64'(event_cnt_o), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/event_streamer.md
# event_streamer

Drains complete events from the event FIFO and forwards them to the host side as a framed 32-bit valid/ready stream. It is the read-side counterpart of the event saver. The saver writes `WORDS_PER_EVENT` 64-bit words per trigger. The streamer pops them back out, prefixes each event with a header beat carrying a running event number, and splits each word into high-then-low 32-bit beats. It runs in the 125 MHz domain next to the FIFO read port.

## Interface
Parameters:
- `WORDS_PER_EVENT`, 16: 64-bit FIFO words per event.
- `HDR_TAG`, 16'hE7E7: constant in the upper half of the header beat.

Ports:
- `clk`, in, 1: 125 MHz system clock; the single clock; all logic on its rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `enable_i`, in, 1: permits starting a new event.
- `dout_i`, in, 64: FIFO read data, valid the cycle after `rd_en_o` (standard, non-FWFT FIFO).
- `empty_i`, in, 1: FIFO empty flag.
- `rd_en_o`, out, 1: FIFO pop strobe.
- `m_data_o`, out, 32: stream data.
- `m_valid_o`, out, 1: stream data valid.
- `m_ready_i`, in, 1: downstream accepts the beat.
- `m_first_o`, out, 1: marks the header beat.
- `m_last_o`, out, 1: marks the final beat of an event.
- `event_cnt_o`, out, 16: number of events fully streamed.
- `busy_o`, out, 1: high whenever the state is not IDLE.

## Operation
FSM states:
- **IDLE**: go to HDR when `enable_i && !empty_i`.
- **HDR**:
  - Drive `m_data_o = {HDR_TAG, event_cnt_o}`, `m_valid_o = 1`, `m_first_o = 1`.
  - On `m_valid_o && m_ready_i`, clear `word_idx` and go to RD.
- **RD**:
  - If `!empty_i`, assert `rd_en_o` for exactly this cycle and go to LAT.
  - Otherwise stay in RD with `rd_en_o = 0`. A partially written event is waited out, not abandoned.
- **LAT**: capture `dout_i` into `word_q`; go to HI.
- **HI**: drive `m_data_o = word_q[63:32]`, `m_valid_o = 1`. On handshake go to LO.
- **LO**: drive `m_data_o = word_q[31:0]`, `m_valid_o = 1`, and `m_last_o = (word_idx == WORDS_PER_EVENT-1)`. On handshake:
  - If `m_last_o` is high, increment `event_cnt_o` and go to IDLE.
  - Otherwise increment `word_idx` and go to RD.

Rules:
- Handshake: a beat transfers on a cycle with `m_valid_o && m_ready_i`. While `m_valid_o` is high and `m_ready_i` is low, `m_data_o`, `m_first_o` and `m_last_o` hold stable. `m_valid_o` never drops without a transfer.
- `rd_en_o` is never asserted when `empty_i` is high, and never outside RD.
- `enable_i` is sampled only in IDLE. Deasserting it mid-event lets the current event finish.
- `word_idx` is `$clog2(WORDS_PER_EVENT)` bits wide.
- `event_cnt_o` wraps from 16'hFFFF to 16'h0000.
- Each event is exactly `2*WORDS_PER_EVENT + 1` beats: 33 with defaults.

## Timing
- Reset (`rst` low at a rising edge):
  - State goes to IDLE.
  - `rd_en_o`, `m_valid_o`, `m_first_o`, `m_last_o`, `busy_o` = 0.
  - `m_data_o`, `event_cnt_o`, `word_idx`, `word_q` = 0.
- Reset mid-event abandons the event. Upstream resets the FIFO on the same `rst`, so no word re-alignment is attempted.
- Latency and throughput:
  - IDLE to header valid: 1 cycle.
  - Each word costs 4 cycles (RD, LAT, HI, LO) with `m_ready_i` high and FIFO non-empty.
  - A full default event takes 1 + 1 + 64 = 66 cycles from start condition to return to IDLE.
- Back-to-back events:
  - IDLE is always visited for one cycle between events.
  - With `enable_i` high and FIFO non-empty, the next header is valid 2 cycles after the last handshake.

## Structure
- Shared package `daq_pkg`:
  - FSM state enum `streamer_state_t` (IDLE, HDR, RD, LAT, HI, LO).
  - Constants `WORDS_PER_EVENT` and `HDR_TAG`, shared with event_saver so both sides agree on frame length.
- Single flat module with no sub-modules; the FSM, word counter and output register all live in event_streamer.

## Test plan
1. **Single event**: 16 words 64'h0000_000i_0000_100i preloaded, `m_ready_i = 1`, `enable_i = 1`.
   - Header 32'hE7E7_0000 with `m_first_o` high, then beats alternating 32'h0000_000i and 32'h0000_100i.
   - `m_last_o` only on the final beat; `event_cnt_o` = 1; 66 cycles total.
2. **Back-pressure**: `m_ready_i` toggled pseudo-randomly.
   - Beat data and flags stay stable while stalled.
   - Beat count and order match scenario 1 exactly; no `rd_en_o` occurs while in HI or LO.
3. **Empty mid-event**: only 5 words present, remaining 11 written 40 cycles later.
   - FSM parks in RD with `rd_en_o` low, then completes.
   - `rd_en_o` is never high while `empty_i` is high.
4. **Enable gating**: `enable_i` low with a full event in the FIFO.
   - No `rd_en_o` and no `m_valid_o`.
   - Dropping `enable_i` during beat 10 still lets all 33 beats complete.
5. **Reset mid-event**: `rst` low for 1 cycle after beat 7.
   - Next cycle: all outputs 0, `busy_o` 0, `event_cnt_o` 0.
6. **Counter wrap**: stream 65 537 events (or force `event_cnt_o` to 16'hFFFF and stream 2 events).
   - Headers read 32'hE7E7_FFFF, then 32'hE7E7_0000.
